stage4ma: RTL and testbench

- Memory-access stage of the 24-bit in-order pipeline; consumes the EX→MA latch bundle.
- Decodes load/store opcodes from instr_in[23:16] and drives a single-outstanding req/ack data-memory port.
- Stalls upstream while a memory transaction is in flight; registers the result bundle for the writeback stage.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/stage4ma_pkg.sv | 46 ++++
 rtl/stage4ma_store_buffer.sv | 57 +++++
 rtl/stage4ma.sv | 220 ++++++++++++++++++++++
 tb/tb_stage4ma.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage4ma_pkg.sv
// stage4ma_pkg: opcode, flag-position and state definitions shared by the
// memory-access stage of the 24-bit in-order pipeline.
package stage4ma_pkg;

  localparam logic [7:0] OPC_R_ADD = 8'h01;
  localparam logic [7:0] OPC_R_SUB = 8'h02;
  localparam logic [7:0] OPC_R_LD  = 8'h10;
  localparam logic [7:0] OPC_I_LDi = 8'h11;
  localparam logic [7:0] OPC_R_ST  = 8'h12;
  localparam logic [7:0] OPC_I_STi = 8'h13;
  localparam logic [7:0] OPC_HLT   = 8'hFF;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_BUSY = 1'b1
  } ma_state_e;

  function automatic logic is_load(input logic [7:0] opc);
    return (opc == OPC_R_LD) || (opc == OPC_I_LDi);
  endfunction

  function automatic logic is_store(input logic [7:0] opc);
    return (opc == OPC_R_ST) || (opc == OPC_I_STi);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] opc);
    return is_load(opc) || is_store(opc);
  endfunction

  // Flags reported for load data: Z and N from the data, C and V cleared.
  function automatic logic [3:0] load_flags(input logic [23:0] data);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (data == '0);
    f[FLAG_N] = data[23];
    f[FLAG_C] = 1'b0;
    f[FLAG_V] = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/stage4ma_store_buffer.sv
// ma_store_buffer: one-entry posted store buffer. Holds a single store and
// requests the data-memory port until the drain ack arrives. Used by stage4ma
// only when STAGE4MA_STORE_BUFFER_EN is defined.
module ma_store_buffer
  import stage4ma_pkg::*;
#(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          ack,
  output logic          full,
  output logic          req,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata
);

  logic          full_q, full_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  // Drain on ack; a push in the same cycle refills the entry.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (ack && full_q) full_d = 1'b0;
    if (push) begin
      full_d = 1'b1;
      addr_d = push_addr;
      data_d = push_data;
    end
  end

  // Entry registers; reset abandons any pending store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full  = full_q;
  assign req   = full_q;
  assign addr  = addr_q;
  assign wdata = data_q;

endmodule

// File: rtl/stage4ma.sv
// stage4ma: memory-access stage. Issues loads/stores on a single-outstanding
// req/ack port, stalls upstream while a transaction is in flight and registers
// the writeback bundle. Optional posted store buffer: STAGE4MA_STORE_BUFFER_EN.
module stage4ma
  import stage4ma_pkg::*;
#(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_in,
  output logic          stall_out,
  input  logic [23:0]   pc_in,
  input  logic [23:0]   instr_in,
  input  logic [3:0]    tgt_gp_in,
  input  logic [3:0]    tgt_sr_in,
  input  logic [23:0]   result_in,
  input  logic [3:0]    flags_in,
  input  logic [23:0]   store_data_in,
  input  logic          branch_taken_in,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          valid_out,
  output logic [23:0]   pc_out,
  output logic [23:0]   instr_out,
  output logic [3:0]    tgt_gp_out,
  output logic [3:0]    tgt_sr_out,
  output logic          branch_taken_out,
  output logic [23:0]   result_out,
  output logic [3:0]    flags_out
);

  ma_state_e     state_q, state_d;
  logic          valid_q, valid_d;
  logic [23:0]   pc_q, pc_d;
  logic [23:0]   instr_q, instr_d;
  logic [3:0]    tgt_gp_q, tgt_gp_d;
  logic [3:0]    tgt_sr_q, tgt_sr_d;
  logic          br_q, br_d;
  logic [23:0]   result_q, result_d;
  logic [3:0]    flags_q, flags_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [7:0]    opc_in;
  logic [23:0]   rdata24;

  assign opc_in  = instr_in[23:16];
  assign rdata24 = 24'(mem_rdata);

`ifdef STAGE4MA_STORE_BUFFER_EN
  logic          sb_push;
  logic [AW-1:0] sb_push_addr;
  logic [DW-1:0] sb_push_data;
  logic          sb_full;
  logic          sb_req;
  logic [AW-1:0] sb_addr;
  logic [DW-1:0] sb_wdata;
  logic          sb_ack;

  // While the buffer holds a store, the port belongs to the drain.
  assign sb_ack = mem_ack & sb_full;

  ma_store_buffer #(.AW(AW), .DW(DW)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .push      (sb_push),
    .push_addr (sb_push_addr),
    .push_data (sb_push_data),
    .ack       (sb_ack),
    .full      (sb_full),
    .req       (sb_req),
    .addr      (sb_addr),
    .wdata     (sb_wdata)
  );
`endif

  // Next-state, bundle capture and completion of the memory transaction.
  always_comb begin
    state_d     = state_q;
    valid_d     = 1'b0;
    pc_d        = pc_q;
    instr_d     = instr_q;
    tgt_gp_d    = tgt_gp_q;
    tgt_sr_d    = tgt_sr_q;
    br_d        = br_q;
    result_d    = result_q;
    flags_d     = flags_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef STAGE4MA_STORE_BUFFER_EN
    sb_push      = 1'b0;
    sb_push_addr = mem_addr_q;
    sb_push_data = mem_wdata_q;
`endif
    case (state_q)
      MA_IDLE: begin
        if (enable_in) begin
          // The bundle goes straight into the output registers; for memory ops
          // result/flags are overwritten at completion, valid_out gates them.
          pc_d     = pc_in;
          instr_d  = instr_in;
          tgt_gp_d = tgt_gp_in;
          tgt_sr_d = tgt_sr_in;
          br_d     = branch_taken_in;
          result_d = result_in;
          flags_d  = flags_in;
          if (is_mem_op(opc_in)) begin
            mem_addr_d  = AW'(result_in);
            mem_wdata_d = DW'(store_data_in);
            mem_we_d    = ~is_load(opc_in);
`ifdef STAGE4MA_STORE_BUFFER_EN
            if (is_store(opc_in) && (!sb_full || sb_ack)) begin
              sb_push      = 1'b1;
              sb_push_addr = AW'(result_in);
              sb_push_data = DW'(store_data_in);
              valid_d      = 1'b1;
            end else begin
              state_d = MA_BUSY;
            end
`else
            state_d = MA_BUSY;
`endif
          end else begin
            valid_d = 1'b1;
          end
        end
      end
      MA_BUSY: begin
`ifdef STAGE4MA_STORE_BUFFER_EN
        // A stalled store waits for the drain, then takes the freed entry;
        // a stalled load only owns the port once the buffer is empty.
        if (mem_we_q) begin
          if (sb_ack) begin
            sb_push = 1'b1;
            valid_d = 1'b1;
            state_d = MA_IDLE;
          end
        end else if (mem_ack && !sb_full) begin
          result_d = rdata24;
          flags_d  = load_flags(rdata24);
          valid_d  = 1'b1;
          state_d  = MA_IDLE;
        end
`else
        if (mem_ack) begin
          if (!mem_we_q) begin
            result_d = rdata24;
            flags_d  = load_flags(rdata24);
          end
          valid_d = 1'b1;
          state_d = MA_IDLE;
        end
`endif
      end
      default: state_d = MA_IDLE;
    endcase
  end

  // State and output registers; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MA_IDLE;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      instr_q     <= '0;
      tgt_gp_q    <= '0;
      tgt_sr_q    <= '0;
      br_q        <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      tgt_gp_q    <= tgt_gp_d;
      tgt_sr_q    <= tgt_sr_d;
      br_q        <= br_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign stall_out        = (state_q == MA_BUSY);
  assign valid_out        = valid_q;
  assign pc_out           = pc_q;
  assign instr_out        = instr_q;
  assign tgt_gp_out       = tgt_gp_q;
  assign tgt_sr_out       = tgt_sr_q;
  assign branch_taken_out = br_q;
  assign result_out       = result_q;
  assign flags_out        = flags_q;

`ifdef STAGE4MA_STORE_BUFFER_EN
  assign mem_req   = sb_req | ((state_q == MA_BUSY) & ~mem_we_q);
  assign mem_we    = sb_full ? 1'b1 : mem_we_q;
  assign mem_addr  = sb_full ? sb_addr : mem_addr_q;
  assign mem_wdata = sb_full ? sb_wdata : mem_wdata_q;
`else
  assign mem_req   = (state_q == MA_BUSY);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`endif

endmodule

// File: tb/tb_stage4ma.sv
// tb_stage4ma: randomized and directed bench for stage4ma with a behavioural
// memory responder and a program-order writeback model.
`timescale 1ns/1ps
module tb_stage4ma;
  import stage4ma_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_in;
  logic        stall_out;
  logic [23:0] pc_in, instr_in, result_in, store_data_in;
  logic [3:0]  tgt_gp_in, tgt_sr_in, flags_in;
  logic        branch_taken_in;
  logic        mem_req, mem_we, mem_ack;
  logic [23:0] mem_addr, mem_wdata, mem_rdata;
  logic        valid_out;
  logic [23:0] pc_out, instr_out, result_out;
  logic [3:0]  tgt_gp_out, tgt_sr_out, flags_out;
  logic        branch_taken_out;

  stage4ma #(.AW(24), .DW(24)) dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .stall_out(stall_out),
    .pc_in(pc_in), .instr_in(instr_in), .tgt_gp_in(tgt_gp_in), .tgt_sr_in(tgt_sr_in),
    .result_in(result_in), .flags_in(flags_in), .store_data_in(store_data_in),
    .branch_taken_in(branch_taken_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out),
    .tgt_gp_out(tgt_gp_out), .tgt_sr_out(tgt_sr_out), .branch_taken_out(branch_taken_out),
    .result_out(result_out), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] pc;
    logic [23:0] instr;
    logic [3:0]  gp;
    logic [3:0]  sr;
    logic [23:0] result;
    logic [3:0]  flags;
    logic        br;
  } wb_t;

  wb_t obs;
  assign obs = {pc_out, instr_out, tgt_gp_out, tgt_sr_out, result_out, flags_out, branch_taken_out};

  wb_t         exp_q[$];
  int unsigned vectors = 0;
  int unsigned errors  = 0;

  logic [23:0] gold_mem[int unsigned];
  logic [23:0] mem_act[int unsigned];
  logic        acc_we_q[$];
  logic [23:0] acc_addr_q[$];
  int          fixed_lat = -1;

  function automatic logic [23:0] init_val(input logic [23:0] a);
    case (a[1:0])
      2'd0:    return 24'h0;
      2'd1:    return {~a[7:0], a[7:0], a[7:0]};
      default: return {a[7:0], a[7:0], a[7:0]};
    endcase
  endfunction

  function automatic logic [23:0] gold_read(input logic [23:0] a);
    return gold_mem.exists(int'(a)) ? gold_mem[int'(a)] : init_val(a);
  endfunction

  function automatic bit op_load(input logic [7:0] o);
    return (o == OPC_R_LD) || (o == OPC_I_LDi);
  endfunction

  function automatic bit op_store(input logic [7:0] o);
    return (o == OPC_R_ST) || (o == OPC_I_STi);
  endfunction

  // Memory responder: one transaction per request, ack after a chosen latency.
  initial begin : responder
    int cnt;
    bit in_txn;
    mem_ack = 1'b0; mem_rdata = '0; in_txn = 1'b0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin mem_ack = 1'b0; mem_rdata = '0; in_txn = 1'b0; end
      if (rst) in_txn = 1'b0;
      else if (mem_req) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end
        if (cnt == 0) begin
          mem_ack = 1'b1;
          acc_we_q.push_back(mem_we);
          acc_addr_q.push_back(mem_addr);
          if (mem_we) mem_act[int'(mem_addr)] = mem_wdata;
          else mem_rdata = mem_act.exists(int'(mem_addr)) ? mem_act[int'(mem_addr)] : init_val(mem_addr);
        end else cnt--;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one instruction, holds it while stalled, records the expected WB bundle.
  task automatic send(input logic [7:0] opc, input logic [23:0] res,
                      input logic [23:0] sdata, input logic [3:0] fl);
    wb_t e;
    logic [23:0] d;
    int n;
    e.pc = 24'($urandom); e.instr = {opc, 16'($urandom)};
    e.gp = 4'($urandom);  e.sr = 4'($urandom); e.br = 1'($urandom);
    enable_in = 1'b1; pc_in = e.pc; instr_in = e.instr; tgt_gp_in = e.gp;
    tgt_sr_in = e.sr; branch_taken_in = e.br; result_in = res;
    flags_in = fl; store_data_in = sdata;
    n = 0;
    @(negedge clk);
    while (stall_out && n < 300) begin @(negedge clk); n++; end
    if (stall_out) begin
      vectors++; errors++;
      $display("FAIL send_accept: stall_out still 1 after %0d cycles, required 0", n);
    end
    if (op_load(opc)) begin
      d = gold_read(res);
      e.result = d;
      e.flags = {2'b00, d[23], d == 24'h0};
    end else begin
      if (op_store(opc)) gold_mem[int'(res)] = sdata;
      e.result = res;
      e.flags = fl;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    enable_in = 1'b0;
    instr_in = {OPC_HLT, 16'h0};
  endtask

  task automatic test_reset();
    rst = 1'b1; enable_in = 1'b0; pc_in = '0; instr_in = '0; tgt_gp_in = '0;
    tgt_sr_in = '0; result_in = '0; flags_in = '0; store_data_in = '0; branch_taken_in = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({obs, valid_out, stall_out, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_state: got bundle %h v=%b s=%b req=%b we=%b a=%h wd=%h, required all 0",
               obs, valid_out, stall_out, mem_req, mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    wb_t e;
    send(OPC_R_ADD, 24'h000123, 24'h0, 4'h5);
    e = exp_q.pop_front();
    @(negedge clk);
    vectors++;
    if (valid_out !== 1'b1 || stall_out !== 1'b0 || result_out !== 24'h000123) begin
      errors++;
      $display("FAIL alu_pass: v=%b s=%b result=%h, required v=1 s=0 result=000123",
               valid_out, stall_out, result_out);
    end
    vectors++;
    if (obs !== e) begin
      errors++;
      $display("FAIL alu_bundle: got %h, required %h", obs, e);
    end
    @(negedge clk);
    vectors++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL alu_single_pulse: valid_out=%b, required 0", valid_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_latency();
    wb_t e;
    int req_c, st_c, bad, i;
    bit found;
    gold_mem[32'h40] = 24'h800000;
    mem_act[32'h40] = 24'h800000;
    fixed_lat = 2;
    send(OPC_R_LD, 24'h000040, 24'h0, 4'hF);
    e = exp_q.pop_front();
    req_c = 0; st_c = 0; bad = 0; found = 1'b0;
    for (i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (valid_out) found = 1'b1;
      else begin
        if (mem_req) begin
          req_c++;
          if (mem_addr !== 24'h000040 || mem_we !== 1'b0) bad++;
        end
        if (stall_out) st_c++;
      end
    end
    vectors++;
    if (!found) begin
      errors++;
      $display("FAIL load_valid: valid_out not seen within 20 cycles, required");
    end
    vectors++;
    if (req_c != 3 || st_c != 3 || bad != 0) begin
      errors++;
      $display("FAIL load_timing: req cycles=%0d stall cycles=%0d bad port=%0d, required 3 3 0",
               req_c, st_c, bad);
    end
    vectors++;
    if (result_out !== 24'h800000 || flags_out !== 4'b0010 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL load_result: result=%h flags=%b req=%b, required 800000 0010 0",
               result_out, flags_out, mem_req);
    end
    vectors++;
    if (obs !== e) begin
      errors++;
      $display("FAIL load_bundle: got %h, required %h", obs, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_ack_first();
    wb_t e;
    int st_c, i, exp_st;
    bit found;
`ifdef STAGE4MA_STORE_BUFFER_EN
    exp_st = 0;
`else
    exp_st = 1;
`endif
    fixed_lat = 0;
    send(OPC_R_ST, 24'h000010, 24'h00ABCD, 4'h9);
    e = exp_q.pop_front();
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 24'h00ABCD || mem_addr !== 24'h000010) begin
      errors++;
      $display("FAIL store_port: req=%b we=%b wdata=%h addr=%h, required 1 1 00abcd 000010",
               mem_req, mem_we, mem_wdata, mem_addr);
    end
    st_c = 0; found = 1'b0;
    for (i = 0; i < 10 && !found; i++) begin
      if (i > 0) @(negedge clk);
      if (valid_out) found = 1'b1;
      else if (stall_out) st_c++;
    end
    vectors++;
    if (!found || st_c != exp_st) begin
      errors++;
      $display("FAIL store_stall: found=%b stall cycles=%0d, required found=1 stall=%0d",
               found, st_c, exp_st);
    end
    vectors++;
    if (obs !== e || result_out !== 24'h000010 || flags_out !== 4'h9) begin
      errors++;
      $display("FAIL store_bundle: got %h, required %h", obs, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int idx[$];
    fixed_lat = 1;
    fork
      begin
        send(OPC_R_LD, 24'h000005, 24'h0, 4'h0);
        send(OPC_R_ADD, 24'($urandom), 24'h0, 4'($urandom));
      end
      begin
        wb_t e;
        for (int c = 0; c < 14; c++) begin
          @(negedge clk);
          if (valid_out) begin
            idx.push_back(c);
            vectors++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL b2b_extra_pulse: valid_out at cycle %0d with nothing outstanding", c);
            end else begin
              e = exp_q.pop_front();
              if (obs !== e) begin
                errors++;
                $display("FAIL b2b_bundle: got %h, required %h", obs, e);
              end
            end
          end
        end
      end
    join
    vectors++;
    if (idx.size() != 2 || idx[1] != idx[0] + 1) begin
      errors++;
      $display("FAIL b2b_timing: pulses=%0d first=%0d second=%0d, required 2 adjacent pulses",
               idx.size(), (idx.size() > 0) ? idx[0] : -1, (idx.size() > 1) ? idx[1] : -1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int i;
    bit found;
    fixed_lat = 20;
    send(OPC_I_LDi, 24'h000008, 24'h0, 4'h3);
    @(negedge clk); @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 24'h000008) begin
      errors++;
      $display("FAIL rst_mid_pre: req=%b addr=%h, required 1 000008", mem_req, mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({obs, valid_out, stall_out, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid_clear: req=%b stall=%b addr=%h bundle %h, required all 0",
               mem_req, stall_out, mem_addr, obs);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    fixed_lat = 1;
    @(posedge clk); #1;
    send(OPC_R_LD, 24'h000040, 24'h0, 4'h0);
    found = 1'b0;
    for (i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (valid_out) found = 1'b1;
    end
    vectors++;
    if (!found || result_out !== 24'h800000 || exp_q.size() != 1 || obs !== exp_q[0]) begin
      errors++;
      $display("FAIL rst_mid_recover: found=%b result=%h, required 1 800000", found, result_out);
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int unsigned n_ops;
    n_ops = 150;
    fixed_lat = -1;
    fork
      begin
        int unsigned r;
        for (int unsigned k = 0; k < n_ops; k++) begin
          repeat ($urandom_range(0, 2)) begin
            enable_in = 1'b0;
            instr_in = {OPC_HLT, 16'($urandom)};
            @(posedge clk); #1;
          end
          r = $urandom_range(0, 5);
          case (r)
            0: send(OPC_R_ADD, 24'($urandom), 24'($urandom), 4'($urandom));
            1: send(OPC_R_SUB, 24'($urandom), 24'($urandom), 4'($urandom));
            2: send(OPC_R_LD,  24'($urandom_range(0, 15)), 24'($urandom), 4'($urandom));
            3: send(OPC_I_LDi, 24'($urandom_range(0, 15)), 24'($urandom), 4'($urandom));
            4: send(OPC_R_ST,  24'($urandom_range(0, 15)), 24'($urandom), 4'($urandom));
            default: send(OPC_I_STi, 24'($urandom_range(0, 15)), 24'($urandom), 4'($urandom));
          endcase
        end
      end
      begin
        int unsigned got, cyc;
        wb_t e;
        got = 0; cyc = 0;
        while (got < n_ops && cyc < 6000) begin
          @(negedge clk);
          cyc++;
          if (valid_out) begin
            got++;
            vectors++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rand_unexpected: valid_out with no outstanding instruction");
            end else begin
              e = exp_q.pop_front();
              if (obs !== e) begin
                errors++;
                $display("FAIL rand_bundle #%0d: got %h, required %h", got, obs, e);
              end
            end
          end
        end
        if (got < n_ops) begin
          vectors++; errors++;
          $display("FAIL rand_timeout: %0d of %0d results seen", got, n_ops);
        end
      end
    join
    @(posedge clk); #1;
  endtask

`ifdef STAGE4MA_STORE_BUFFER_EN
  task automatic test_store_buffer();
    int vidx[$];
    bit st_stall[$];
    fixed_lat = 1;
    repeat (6) @(posedge clk);
    #1;
    acc_we_q.delete(); acc_addr_q.delete();
    fork
      begin
        send(OPC_R_ST, 24'h000020, 24'h5A5A01, 4'h6);
        send(OPC_R_LD, 24'h000020, 24'h0, 4'h0);
      end
      begin
        wb_t e;
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          if (valid_out) begin
            vidx.push_back(c);
            st_stall.push_back(stall_out);
            vectors++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL sb_extra_pulse: cycle %0d", c);
            end else begin
              e = exp_q.pop_front();
              if (obs !== e) begin
                errors++;
                $display("FAIL sb_bundle: got %h, required %h", obs, e);
              end
            end
          end
        end
      end
    join
    vectors++;
    if (vidx.size() != 2 || vidx[0] != 1 || st_stall[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_no_stall: pulses=%0d first=%0d, required 2 pulses, store at cycle 1 unstalled",
               vidx.size(), (vidx.size() > 0) ? vidx[0] : -1);
    end
    vectors++;
    if (acc_we_q.size() != 2 || acc_we_q[0] !== 1'b1 || acc_we_q[1] !== 1'b0 ||
        acc_addr_q[0] !== 24'h000020 || acc_addr_q[1] !== 24'h000020) begin
      errors++;
      $display("FAIL sb_order: %0d accesses, required write then read of 000020", acc_we_q.size());
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_latency();
    test_store_ack_first();
    test_back_to_back();
    test_reset_mid();
`ifdef STAGE4MA_STORE_BUFFER_EN
    test_store_buffer();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
